// File: rtl/la_spram_arb_pkg.sv
// Shared definitions for the single-port RAM arbiter: FSM state encoding
// and the pointer-width helper used to size round-robin indices.
package la_spram_arb_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } arb_state_t;

   // Ceiling log2, never less than 1 so a pointer always has at least one bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/la_rr_arbiter.sv
// Combinational round-robin picker: the winner is the first asserted request
// at or after ptr, scanning upward and wrapping modulo N.
module la_rr_arbiter
   import la_spram_arb_pkg::*;
#(
   parameter int  N  = 2,
   localparam int PW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx
);

   logic [PW-1:0] pos;
   logic          found;

   // Scan N positions starting at ptr; the first hit wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      pos     = '0;
      for (int k = 0; k < N; k++) begin
         if (int'(ptr) + k >= N) begin
            pos = PW'(int'(ptr) + k - N);
         end else begin
            pos = PW'(int'(ptr) + k);
         end
         if (!found && req[pos]) begin
            found    = 1'b1;
            gnt[pos] = 1'b1;
            gnt_idx  = pos;
         end
      end
   end

endmodule

// File: rtl/la_spram_arbiter.sv
// Round-robin sharing of one single-port RAM among N requesters.
// Grants are same-cycle; read data returns one cycle after acceptance.
// Optional feature macro: LA_SPRAM_ARB_INIT_EN adds a post-reset zero-fill
// sequencer that writes every RAM address before requesters are served.
module la_spram_arbiter
   import la_spram_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int DW = 32,
   parameter int AW = 10
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    req_valid,
   output logic [N-1:0]    req_ready,
   input  logic [N-1:0]    req_we,
   input  logic [N*AW-1:0] req_addr,
   input  logic [N*DW-1:0] req_wmask,
   input  logic [N*DW-1:0] req_din,
   output logic [N-1:0]    rsp_valid,
   output logic [DW-1:0]   rsp_dout,
   output logic            init_done,
   output logic            mem_ce,
   output logic            mem_we,
   output logic [DW-1:0]   mem_wmask,
   output logic [DW-1:0]   mem_din,
   output logic [AW-1:0]   mem_addr,
   input  logic [DW-1:0]   mem_dout
);

   localparam int PW = clog2(N);

   logic [AW-1:0] addr_arr  [N];
   logic [DW-1:0] wmask_arr [N];
   logic [DW-1:0] din_arr   [N];

   logic [N-1:0]  gnt;
   logic [PW-1:0] gnt_idx;
   logic          any_gnt;

   logic [PW-1:0] ptr_q, ptr_d;
   logic [N-1:0]  rsp_valid_q, rsp_valid_d;

   logic          in_run;
   logic          in_init;
   logic [AW-1:0] init_addr;

   // Unpack the flat per-requester buses into indexable arrays.
   for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*AW +: AW];
      assign wmask_arr[gi] = req_wmask[gi*DW +: DW];
      assign din_arr[gi]   = req_din[gi*DW +: DW];
   end

   la_rr_arbiter #(.N(N)) u_arb (
      .req     (req_valid),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign any_gnt = |gnt;

`ifdef LA_SPRAM_ARB_INIT_EN
   arb_state_t    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          init_done_q, init_done_d;

   // Zero-fill sequencing: one address per cycle, hand over to RUN after the last.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_done_d = init_done_q;
      if (state_q == ST_INIT) begin
         cnt_d = cnt_q + AW'(1);
         if (cnt_q == {AW{1'b1}}) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
         end
      end
   end

   assign in_run    = (state_q == ST_RUN);
   assign in_init   = (state_q == ST_INIT);
   assign init_addr = cnt_q;
   assign init_done = init_done_q;
`else
   assign in_run    = 1'b1;
   assign in_init   = 1'b0;
   assign init_addr = '0;
   assign init_done = 1'b1;
`endif

   // RAM port mux: fill pattern during INIT, the granted request during RUN.
   always_comb begin
      req_ready = '0;
      mem_ce    = 1'b0;
      mem_we    = 1'b0;
      mem_wmask = '0;
      mem_din   = '0;
      mem_addr  = '0;
      if (!reset) begin
         if (in_init) begin
            mem_ce    = 1'b1;
            mem_we    = 1'b1;
            mem_wmask = '1;
            mem_addr  = init_addr;
         end else if (in_run) begin
            req_ready = gnt;
            mem_ce    = any_gnt;
            mem_we    = |(gnt & req_we);
            for (int i = 0; i < N; i++) begin
               if (gnt[i]) begin
                  mem_addr  = mem_addr  | addr_arr[i];
                  mem_wmask = mem_wmask | wmask_arr[i];
                  mem_din   = mem_din   | din_arr[i];
               end
            end
         end
      end
   end

   // Pointer advances past the winner; an accepted read schedules its response.
   always_comb begin
      ptr_d       = ptr_q;
      rsp_valid_d = '0;
      if (in_run && any_gnt) begin
         ptr_d       = (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + PW'(1);
         rsp_valid_d = gnt & ~req_we;
      end
   end

   // All state registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q       <= '0;
         rsp_valid_q <= '0;
`ifdef LA_SPRAM_ARB_INIT_EN
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
`endif
      end else begin
         ptr_q       <= ptr_d;
         rsp_valid_q <= rsp_valid_d;
`ifdef LA_SPRAM_ARB_INIT_EN
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= init_done_d;
`endif
      end
   end

   // A reset arriving while a response is due suppresses that response.
   assign rsp_valid = reset ? '0 : rsp_valid_q;
   assign rsp_dout  = (|rsp_valid) ? mem_dout : '0;

endmodule

// File: tb/tb_la_spram_arbiter.sv
// Bench for la_spram_arbiter (N=3, DW=32, AW=4) with a behavioural RAM and
// a cycle-level reference model; honours LA_SPRAM_ARB_INIT_EN when defined.
module tb_la_spram_arbiter;

   localparam int N     = 3;
   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
`ifdef LA_SPRAM_ARB_INIT_EN
   localparam bit INIT_EN = 1'b1;
`else
   localparam bit INIT_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    req_we;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wmask;
   logic [N*DW-1:0] req_din;
   logic [N-1:0]    rsp_valid;
   logic [DW-1:0]   rsp_dout;
   logic            init_done;
   logic            mem_ce;
   logic            mem_we;
   logic [DW-1:0]   mem_wmask;
   logic [DW-1:0]   mem_din;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_dout;

   la_spram_arbiter #(.N(N), .DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wmask (req_wmask),
      .req_din   (req_din),
      .rsp_valid (rsp_valid),
      .rsp_dout  (rsp_dout),
      .init_done (init_done),
      .mem_ce    (mem_ce),
      .mem_we    (mem_we),
      .mem_wmask (mem_wmask),
      .mem_din   (mem_din),
      .mem_addr  (mem_addr),
      .mem_dout  (mem_dout)
   );

   always #5 clk = ~clk;

   // Behavioural single-port RAM: bit-masked write, registered read.
   logic [DW-1:0] ram [DEPTH];
   logic [DW-1:0] ram_q;
   initial begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 32'hA5A5_0000 | i;
      ram_q <= '0;
      forever begin
         @(posedge clk);
         if (mem_ce) begin
            if (mem_we) ram[mem_addr] <= (ram[mem_addr] & ~mem_wmask) | (mem_din & mem_wmask);
            else        ram_q <= ram[mem_addr];
         end
      end
   end
   assign mem_dout = ram_q;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: decides the winner by scanning from the remembered
   // pointer, keeps its own copy of memory, and checks every cycle.
   initial begin : model
      int            m_ptr;
      int            m_pend;
      int            m_init_left;
      int            w;
      int            idx;
      logic [DW-1:0] m_mem [DEPTH];
      logic [DW-1:0] m_pend_data;
      logic [N-1:0]  e_ready;
      logic          e_ce, e_we, e_done;
      logic [DW-1:0] e_wmask, e_din;
      logic [AW-1:0] e_addr;
      logic [N-1:0]  e_rv;
      logic [DW-1:0] e_rd;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'hA5A5_0000 | i;
      m_ptr = 0; m_pend = -1; m_pend_data = '0; m_init_left = 0;
      forever begin
         @(negedge clk);
         e_ready = '0; e_ce = 0; e_we = 0; e_wmask = '0; e_din = '0; e_addr = '0;
         e_rv = '0; e_rd = '0; e_done = 1'b1;
         if (reset) begin
            m_ptr = 0; m_pend = -1;
            m_init_left = INIT_EN ? DEPTH : 0;
         end else begin
            if (m_pend >= 0) begin
               e_rv = N'(1) << m_pend;
               e_rd = m_pend_data;
            end
            m_pend = -1;
            if (m_init_left > 0) begin
               e_done  = 1'b0;
               e_ce    = 1; e_we = 1; e_wmask = '1;
               e_addr  = AW'(DEPTH - m_init_left);
               m_mem[e_addr] = '0;
               m_init_left--;
            end else begin
               w = -1;
               for (int k = 0; k < N; k++) begin
                  idx = (m_ptr + k) % N;
                  if (w < 0 && req_valid[idx]) w = idx;
               end
               if (w >= 0) begin
                  e_ready = N'(1) << w;
                  e_ce    = 1;
                  e_we    = req_we[w];
                  e_addr  = req_addr[w*AW +: AW];
                  e_wmask = req_wmask[w*DW +: DW];
                  e_din   = req_din[w*DW +: DW];
                  if (e_we) m_mem[e_addr] = (m_mem[e_addr] & ~e_wmask) | (e_din & e_wmask);
                  else begin
                     m_pend      = w;
                     m_pend_data = m_mem[e_addr];
                  end
                  m_ptr = (w + 1) % N;
               end
            end
            chk("m_init_done", init_done, e_done);
         end
         chk("m_req_ready", req_ready, e_ready);
         chk("m_mem_ce", mem_ce, e_ce);
         chk("m_mem_we", mem_we, e_we);
         chk("m_mem_addr", mem_addr, e_addr);
         chk("m_mem_wmask", mem_wmask, e_wmask);
         chk("m_mem_din", mem_din, e_din);
         chk("m_rsp_valid", rsp_valid, e_rv);
         chk("m_rsp_dout", rsp_dout, e_rd);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      req_valid = '0; req_we = '0; req_addr = '0; req_wmask = '0; req_din = '0;
   endtask

   task automatic set_req(input int r, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] m, input logic [DW-1:0] d);
      req_valid[r]          = 1'b1;
      req_we[r]             = we;
      req_addr[r*AW +: AW]  = a;
      req_wmask[r*DW +: DW] = m;
      req_din[r*DW +: DW]   = d;
   endtask

   // Leaves the bench in the last cycle before requests can be granted.
   task automatic release_reset();
      tick();
      reset = 1'b0;
      clr();
      if (INIT_EN) repeat (DEPTH - 1) tick();
   endtask

   task automatic do_reset();
      tick();
      reset = 1'b1;
      clr();
      release_reset();
   endtask

   initial begin : timeout
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   int fair_exp [6] = '{1, 2, 4, 1, 2, 4};

   initial begin : stimulus
      clr();
      reset = 1'b1;
      tick();
      tick();
      @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_mem_ce", mem_ce, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      release_reset();
      if (INIT_EN) begin
         @(negedge clk);
         chk("fill_last_addr", mem_addr, DEPTH - 1);
         chk("fill_last_we", mem_we, 1);
         chk("fill_done_low", init_done, 0);
      end

      // Zero-fill visible through a read of address 5
      tick(); set_req(0, 0, 5, '0, '0);
      @(negedge clk);
      chk("done_high", init_done, 1);
      chk("rd5_ready", req_ready, 3'b001);
      tick(); clr();
      @(negedge clk);
      chk("rd5_valid", rsp_valid, 3'b001);
      chk("rd5_data", rsp_dout, INIT_EN ? 32'h0 : 32'hA5A5_0005);

      // Single requester write then read
      tick(); set_req(0, 1, 3, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
      @(negedge clk); chk("wr3_ready", req_ready, 3'b001);
      tick(); clr(); set_req(0, 0, 3, '0, '0);
      @(negedge clk); chk("rd3_ready", req_ready, 3'b001); chk("wr_no_rsp", rsp_valid, 0);
      tick(); clr();
      @(negedge clk); chk("rd3_valid", rsp_valid, 3'b001); chk("rd3_data", rsp_dout, 32'hDEAD_BEEF);

      // Partial mask, write by requester 1 then read by requester 2
      tick(); set_req(1, 1, 7, 32'hFFFF_FFFF, 32'h0);
      @(negedge clk); chk("clr7_ready", req_ready, 3'b010);
      tick(); clr(); set_req(1, 1, 7, 32'h0000_FF00, 32'hFFFF_FFFF);
      @(negedge clk); chk("mask7_ready", req_ready, 3'b010);
      tick(); clr(); set_req(2, 0, 7, '0, '0);
      @(negedge clk); chk("rd7_ready", req_ready, 3'b100);
      tick(); clr();
      @(negedge clk); chk("rd7_valid", rsp_valid, 3'b100); chk("rd7_data", rsp_dout, 32'h0000_FF00);

      // Fairness from ptr = 0 with all three holding reads
      do_reset();
      tick();
      set_req(0, 0, 7, '0, '0); set_req(1, 0, 3, '0, '0); set_req(2, 0, 5, '0, '0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("fair_ready", req_ready, fair_exp[i]);
         if (i > 0) chk("fair_rsp", rsp_valid, fair_exp[i-1]);
         tick();
      end
      clr();
      @(negedge clk); chk("fair_rsp_last", rsp_valid, 3'b100);

      // Read accepted, then reset in the following cycle
      tick(); set_req(0, 0, 3, '0, '0);
      @(negedge clk); chk("pre_rst_ready", req_ready, 3'b001);
      tick(); clr(); reset = 1'b1; set_req(0, 0, 3, '0, '0); set_req(1, 0, 3, '0, '0);
      @(negedge clk);
      chk("rst_drop_valid", rsp_valid, 0);
      chk("rst_drop_dout", rsp_dout, 0);
      chk("rst_ready_low", req_ready, 0);
      release_reset();
      tick(); set_req(0, 0, 3, '0, '0); set_req(1, 0, 3, '0, '0);
      @(negedge clk); chk("ptr_reset", req_ready, 3'b001);
      tick(); clr();
      @(negedge clk); chk("post_rst_data", rsp_dout, INIT_EN ? 32'h0 : 32'hDEAD_BEEF);

      // Withdrawn request: requester 1 drops before being served
      tick(); set_req(2, 0, 3, '0, '0);
      @(negedge clk); chk("wd_ready2", req_ready, 3'b100);
      tick(); clr(); set_req(1, 0, 3, '0, '0);
      @(negedge clk); chk("wd_ready1", req_ready, 3'b010);
      tick(); clr();
      @(negedge clk); chk("wd_idle_ce", mem_ce, 0);

      // Reset in the middle of the fill restarts it
      if (INIT_EN) begin
         tick(); reset = 1'b1;
         tick(); reset = 1'b0;
         repeat (7) tick();
         @(negedge clk); chk("mid_addr7", mem_addr, 7);
         tick(); reset = 1'b1;
         tick(); reset = 1'b0;
         @(negedge clk); chk("mid_restart_addr", mem_addr, 0); chk("mid_done_low", init_done, 0);
         repeat (DEPTH - 1) tick();
         @(negedge clk); chk("mid_done_still_low", init_done, 0);
         tick();
         @(negedge clk); chk("mid_done_high", init_done, 1);
      end

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/la_spram_arbiter.md
# la_spram_arbiter

Round-robin arbiter and sequencer that shares one single-port RAM (an `la_spram` instance) among N requesters. Each requester issues reads and writes over a valid/ready handshake. The block selects one request per cycle, drives the RAM port, and routes the read data back to the requester whose read was accepted. An optional post-reset sequencer zero-fills the RAM before any requester is served.

## Interface
Parameters:
- `N`, 2, number of requesters (2..8).
- `DW`, 32, data width; must match the RAM instance.
- `AW`, 10, address width; must match the RAM instance.

Ports:
- `clk`  in  1  single clock for the block and the RAM.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  N  request valid, one bit per requester.
- `req_ready`  out  N  request accepted this cycle, one-hot or zero.
- `req_we`  in  N  1 = write, 0 = read.
- `req_addr`  in  N*AW  address; requester i occupies bits [i*AW +: AW].
- `req_wmask`  in  N*DW  per-bit write mask; requester i occupies [i*DW +: DW].
- `req_din`  in  N*DW  write data; requester i occupies [i*DW +: DW].
- `rsp_valid`  out  N  read data valid for requester i.
- `rsp_dout`  out  DW  read data, shared by all requesters; qualified by `rsp_valid`.
- `init_done`  out  1  RAM is available to requesters.
- `mem_ce`, `mem_we`  out  1  RAM chip enable and write enable.
- `mem_wmask`, `mem_din`  out  DW  RAM write mask and write data.
- `mem_addr`  out  AW  RAM address.
- `mem_dout`  in  DW  RAM read data; valid one cycle after a read.

## Operation
- FSM states: INIT (only when the macro is defined) and RUN. Reset enters INIT if the macro is defined, otherwise RUN.
- RUN, grant:
  - Among the asserted `req_valid` bits, the winner is the first index at or after `ptr`, wrapping modulo N.
  - `req_ready[winner]` = 1 in the same cycle (combinational). All other `req_ready` bits are 0.
- RUN, RAM drive:
  - When a winner exists, the winner's request drives `mem_ce` = 1, `mem_we` = `req_we[winner]`, and the winner's `mem_addr`, `mem_wmask` and `mem_din`.
  - When no request is valid, `mem_ce` = 0 and the other `mem_*` outputs are 0.
- Pointer update: after each grant, `ptr` ← (winner + 1) mod N. Without a grant, `ptr` holds.
- Requester contract: hold `req_valid` and the payload stable until `req_ready` is seen. Dropping `req_valid` before the grant is permitted; the request is simply withdrawn.
- Read response:
  - An accepted read sets `rsp_valid[winner]` = 1 on the next cycle, with `rsp_dout` = `mem_dout`.
  - An accepted write produces no response.
  - `rsp_dout` = 0 when no bit of `rsp_valid` is set.
- INIT:
  - `req_ready` = 0, `mem_ce` = 1, `mem_we` = 1, `mem_wmask` = all ones, `mem_din` = 0, `mem_addr` = `cnt`.
  - `cnt` counts from 0 to 2^AW−1, one address per cycle.
  - After writing address 2^AW−1, the FSM moves to RUN and `init_done` rises.
- Reset values: `req_ready` = 0, `rsp_valid` = 0, `rsp_dout` = 0, `mem_ce` = 0, `ptr` = 0, `cnt` = 0, and `init_done` = 0 with the macro (1 without it). With the macro, the `mem_*` outputs take their INIT values in the first cycle after reset.

## Timing
- Grant latency: 0 cycles (same cycle). Read latency: 1 cycle from acceptance to `rsp_valid`.
- Throughput: one access per cycle. Back-to-back grants to the same requester are allowed when it is the only one requesting.
- Write followed by read: a write to address A in cycle t and a read of A in cycle t+1 (from any requester) returns the new data in cycle t+2.
- Reset asserted in the cycle after a read was accepted: `rsp_valid` stays 0 and the response is dropped.
- Reset asserted during INIT: `cnt` restarts at 0 and the full fill repeats.
- INIT takes exactly 2^AW cycles. `init_done` is 1 starting on cycle 2^AW after reset deasserts.

## Configuration
- Macro: `LA_SPRAM_ARB_INIT_EN`.
- Defined: the INIT zero-fill sequencer is present, with the behaviour and timing given above.
- Undefined: no INIT state and no `cnt` register. `init_done` is tied to 1 and requests are served from the first cycle after reset.

## Structure
- Package `la_spram_arb_pkg` holds the FSM state encoding (`ST_INIT` = 1'b0, `ST_RUN` = 1'b1) and the pointer-width function clog2(N).
- Sub-module `la_rr_arbiter` (parameter N) contains:
  - Inputs: `req[N]`, `ptr`.
  - Outputs: one-hot `gnt[N]` and a binary `gnt_idx`.
  - Logic: combinational only.
- The top level owns `ptr`, the FSM, `cnt`, the RAM-port mux and the response register.

## Test plan
- Zero-fill (macro on, AW = 4): deassert reset → `mem_we` = 1 for addresses 0..15 over 16 cycles, then `init_done` = 1. A read of address 5 then returns 0x00000000.
- Single requester: req0 writes 0xDEADBEEF to address 3 with a full mask, then reads address 3 → `req_ready[0]` = 1 both cycles; `rsp_valid[0]` = 1 one cycle after the read, with `rsp_dout` = 0xDEADBEEF.
- Fairness: N = 3, all requesters hold reads continuously from `ptr` = 0 → grant order 0,1,2,0,1,2. Each `rsp_valid` bit lags its grant by 1 cycle.
- Partial mask: write 0xFFFFFFFF with mask 0x0000FF00 over 0x00000000, then read → 0x0000FF00.
- Mid-init reset: assert reset at `cnt` = 7 → `cnt` = 0 and `init_done` = 0; `init_done` rises 16 cycles after the release.
- Read then reset: reset is asserted the cycle after a read grant → `rsp_valid` = 0, `ptr` = 0, `req_ready` = 0.
